rtc_display_sel: RTL and testbench

//  Parametrised source selector between the RTC read path and the user-entry path, feeding the VGA text renderer.
//  - Clock and timer field groups are handled separately.
//  - Registered outputs; edit cursor blink mask.
//  - Frozen RTC snapshot during edit.
//  - One-cycle commit pulses on edit exit.
//  - Sits between the RTC read FSM / user-entry block and the VGA module.

---
 rtl/rtc_display_sel_pkg.sv | 29 ++
 rtl/rtc_display_sel_blink_gen.sv | 42 ++++
 rtl/rtc_display_sel.sv | 173 +++++++++++++++++
 tb/tb_rtc_display_sel.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_display_sel_pkg.sv
// Shared definitions for the RTC / user-entry display selector: FSM encoding,
// field index constants and small state helpers.
package rtc_display_sel_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StArm     = 2'b01,
        StEditClk = 2'b10,
        StEditTmr = 2'b11
    } state_e;

    // Clock/date field indices within the clock group
    localparam int unsigned F_SEG  = 0;
    localparam int unsigned F_MIN  = 1;
    localparam int unsigned F_HORA = 2;
    localparam int unsigned F_DIA  = 3;
    localparam int unsigned F_MES  = 4;
    localparam int unsigned F_ANO  = 5;

    // Timer field indices within the timer group
    localparam int unsigned F_SEG_T  = 0;
    localparam int unsigned F_MIN_T  = 1;
    localparam int unsigned F_HORA_T = 2;

    function automatic logic is_edit(input state_e s);
        return (s == StEditClk) || (s == StEditTmr);
    endfunction

endpackage

// File: rtl/rtc_display_sel_blink_gen.sv
// Edit-cursor blink phase generator: toggles o_phase every BLINK_DIV enabled
// cycles; a clear request returns counter and phase to zero.
module blink_gen #(
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_phase
);

    localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_phase;
    logic            w_wrap;

    assign w_wrap = (r_cnt == CntMax);

    // Clear wins over enable so a fresh edit always starts in the visible phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_en) begin
            if (w_wrap) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/rtc_display_sel.sv
// Selects between live RTC data, a frozen RTC snapshot and user-entry data for
// the VGA text renderer, with edit-cursor blanking and commit pulses.
module rtc_display_sel
    import rtc_display_sel_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned N_CLK     = 6,
    parameter int unsigned N_TMR     = 3,
    parameter int unsigned BLINK_DIV = 12500000,
    parameter int unsigned CUR_W     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en_cfg,
    input  logic                    i_sel_tmr,
    input  logic [CUR_W-1:0]        i_cursor,
    input  logic [N_CLK*DATA_W-1:0] i_usr_clk,
    input  logic [N_TMR*DATA_W-1:0] i_usr_tmr,
    input  logic [N_CLK*DATA_W-1:0] i_rtc_clk,
    input  logic [N_TMR*DATA_W-1:0] i_rtc_tmr,
    output logic [N_CLK*DATA_W-1:0] o_vga_clk,
    output logic [N_TMR*DATA_W-1:0] o_vga_tmr,
    output logic [N_CLK-1:0]        o_blank_clk,
    output logic [N_TMR-1:0]        o_blank_tmr,
    output logic                    o_configurate,
    output logic                    o_crono,
    output logic                    o_commit_clk,
    output logic                    o_commit_tmr
);

    state_e r_state;
    state_e w_state_nxt;

    logic [N_CLK*DATA_W-1:0] r_snap_clk;
    logic [N_TMR*DATA_W-1:0] r_snap_tmr;

    logic [N_CLK*DATA_W-1:0] w_vga_clk_nxt;
    logic [N_TMR*DATA_W-1:0] w_vga_tmr_nxt;
    logic [N_CLK-1:0]        w_blank_clk_nxt;
    logic [N_TMR-1:0]        w_blank_tmr_nxt;
    logic                    w_configurate_nxt;
    logic                    w_crono_nxt;
    logic                    w_commit_clk_nxt;
    logic                    w_commit_tmr_nxt;

    logic w_blink_en;
    logic w_blink_clr;
    logic w_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // en_cfg is tested before sel_tmr in every edit state so an exit takes priority
    always_comb begin
        w_state_nxt       = StRun;
        w_configurate_nxt = 1'b0;
        w_crono_nxt       = 1'b0;
        w_commit_clk_nxt  = 1'b0;
        w_commit_tmr_nxt  = 1'b0;
        case (r_state)
            StRun: begin
                w_state_nxt = i_en_cfg ? StArm : StRun;
            end
            StArm: begin
                if (!i_en_cfg) begin
                    w_state_nxt = StRun;
                end else begin
                    w_state_nxt = i_sel_tmr ? StEditTmr : StEditClk;
                end
            end
            StEditClk: begin
                w_configurate_nxt = 1'b1;
                if (!i_en_cfg) begin
                    w_state_nxt      = StRun;
                    w_commit_clk_nxt = 1'b1;
                end else begin
                    w_state_nxt = i_sel_tmr ? StEditTmr : StEditClk;
                end
            end
            StEditTmr: begin
                w_configurate_nxt = 1'b1;
                w_crono_nxt       = 1'b1;
                if (!i_en_cfg) begin
                    w_state_nxt      = StRun;
                    w_commit_tmr_nxt = 1'b1;
                end else begin
                    w_state_nxt = i_sel_tmr ? StEditTmr : StEditClk;
                end
            end
            default: begin
                w_state_nxt = StRun;
            end
        endcase
    end

    // RTC values are frozen on the ARM cycle for display while the timer is edited
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_clk <= '0;
            r_snap_tmr <= '0;
        end else if (r_state == StArm) begin
            r_snap_clk <= i_rtc_clk;
            r_snap_tmr <= i_rtc_tmr;
        end
    end

    assign w_blink_en  = is_edit(r_state);
    assign w_blink_clr = (w_state_nxt != r_state);

    blink_gen #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink_gen (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_blink_en),
        .i_clr  (w_blink_clr),
        .o_phase(w_phase)
    );

    for (genvar i = 0; i < N_CLK; i++) begin : g_clk_field
        logic [DATA_W-1:0] w_field;
        always_comb begin
            w_field = i_rtc_clk[i*DATA_W +: DATA_W];
            if (r_state == StEditClk) begin
                w_field = i_usr_clk[i*DATA_W +: DATA_W];
            end else if (r_state == StEditTmr) begin
                w_field = r_snap_clk[i*DATA_W +: DATA_W];
            end
        end
        assign w_vga_clk_nxt[i*DATA_W +: DATA_W] = w_field;
        assign w_blank_clk_nxt[i] = (r_state == StEditClk) && (i_cursor == CUR_W'(i)) && w_phase;
    end

    for (genvar i = 0; i < N_TMR; i++) begin : g_tmr_field
        logic [DATA_W-1:0] w_field;
        always_comb begin
            w_field = i_rtc_tmr[i*DATA_W +: DATA_W];
            if (r_state == StEditTmr) begin
                w_field = i_usr_tmr[i*DATA_W +: DATA_W];
            end
        end
        assign w_vga_tmr_nxt[i*DATA_W +: DATA_W] = w_field;
        assign w_blank_tmr_nxt[i] = (r_state == StEditTmr) && (i_cursor == CUR_W'(i)) && w_phase;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_vga_clk     <= '0;
            o_vga_tmr     <= '0;
            o_blank_clk   <= '0;
            o_blank_tmr   <= '0;
            o_configurate <= 1'b0;
            o_crono       <= 1'b0;
            o_commit_clk  <= 1'b0;
            o_commit_tmr  <= 1'b0;
        end else begin
            o_vga_clk     <= w_vga_clk_nxt;
            o_vga_tmr     <= w_vga_tmr_nxt;
            o_blank_clk   <= w_blank_clk_nxt;
            o_blank_tmr   <= w_blank_tmr_nxt;
            o_configurate <= w_configurate_nxt;
            o_crono       <= w_crono_nxt;
            o_commit_clk  <= w_commit_clk_nxt;
            o_commit_tmr  <= w_commit_tmr_nxt;
        end
    end

endmodule

// File: tb/tb_rtc_display_sel.sv
// Randomized bench for rtc_display_sel against a cycle-level behavioural model,
// preceded by directed scenarios for the main edit/commit/blink cases.
module tb_rtc_display_sel;

    localparam int unsigned DW = 8;
    localparam int unsigned NC = 6;
    localparam int unsigned NT = 3;
    localparam int unsigned BD = 4;
    localparam int unsigned CW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              en_cfg;
    logic              sel_tmr;
    logic [CW-1:0]     cursor;
    logic [NC*DW-1:0]  usr_clk, rtc_clk, vga_clk;
    logic [NT*DW-1:0]  usr_tmr, rtc_tmr, vga_tmr;
    logic [NC-1:0]     blank_clk;
    logic [NT-1:0]     blank_tmr;
    logic              configurate, crono, commit_clk, commit_tmr;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: mode 0=run 1=arm 2=edit clock 3=edit timer; dwell = cycles held in an edit mode
    int               m_mode;
    int               m_dwell;
    logic [NC*DW-1:0] m_snap;

    always #5 clk = ~clk;

    rtc_display_sel #(
        .DATA_W   (DW),
        .N_CLK    (NC),
        .N_TMR    (NT),
        .BLINK_DIV(BD),
        .CUR_W    (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_en_cfg     (en_cfg),
        .i_sel_tmr    (sel_tmr),
        .i_cursor     (cursor),
        .i_usr_clk    (usr_clk),
        .i_usr_tmr    (usr_tmr),
        .i_rtc_clk    (rtc_clk),
        .i_rtc_tmr    (rtc_tmr),
        .o_vga_clk    (vga_clk),
        .o_vga_tmr    (vga_tmr),
        .o_blank_clk  (blank_clk),
        .o_blank_tmr  (blank_tmr),
        .o_configurate(configurate),
        .o_crono      (crono),
        .o_commit_clk (commit_clk),
        .o_commit_tmr (commit_tmr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_dwell = 0;
        m_snap  = '0;
    endtask

    // Predict the outputs registered at the coming edge, advance the model, check after the edge
    task automatic step();
        logic [NC*DW-1:0] e_vga_clk;
        logic [NT*DW-1:0] e_vga_tmr;
        logic [NC-1:0]    e_blank_clk;
        logic [NT-1:0]    e_blank_tmr;
        logic             phase;
        int               nxt;
        phase       = (m_mode >= 2) ? (((m_dwell / BD) % 2) == 1) : 1'b0;
        e_vga_clk   = (m_mode == 2) ? usr_clk : (m_mode == 3) ? m_snap : rtc_clk;
        e_vga_tmr   = (m_mode == 3) ? usr_tmr : rtc_tmr;
        e_blank_clk = '0;
        e_blank_tmr = '0;
        if (m_mode == 2 && int'(cursor) < NC) e_blank_clk[cursor] = phase;
        if (m_mode == 3 && int'(cursor) < NT) e_blank_tmr[cursor] = phase;
        if (!en_cfg)          nxt = 0;
        else if (m_mode == 0) nxt = 1;
        else                  nxt = sel_tmr ? 3 : 2;
        @(posedge clk);
        #1;
        check("vga_clk", 64'(vga_clk), 64'(e_vga_clk));
        check("vga_tmr", 64'(vga_tmr), 64'(e_vga_tmr));
        check("blank_clk", 64'(blank_clk), 64'(e_blank_clk));
        check("blank_tmr", 64'(blank_tmr), 64'(e_blank_tmr));
        check("configurate", 64'(configurate), 64'(m_mode >= 2));
        check("crono", 64'(crono), 64'(m_mode == 3));
        check("commit_clk", 64'(commit_clk), 64'(m_mode == 2 && !en_cfg));
        check("commit_tmr", 64'(commit_tmr), 64'(m_mode == 3 && !en_cfg));
        if (m_mode == 1) m_snap = rtc_clk;
        m_dwell = (nxt == m_mode && m_mode >= 2) ? m_dwell + 1 : 0;
        m_mode  = nxt;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {vga_clk, vga_tmr[7:0]}, 64'd0);
        check(tag, 64'({vga_tmr, blank_clk, blank_tmr, configurate, crono,
                        commit_clk, commit_tmr}), 64'd0);
    endtask

    // Reset is asserted between edges and released on a falling edge
    task automatic reset_mid();
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        en_cfg = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic rand_inputs();
        logic [63:0] r;
        if ($urandom_range(11) == 0) en_cfg = ~en_cfg;
        if ($urandom_range(9) == 0) sel_tmr = ~sel_tmr;
        if ($urandom_range(7) == 0) cursor = CW'($urandom_range(7));
        r = {$urandom(), $urandom()};
        if ($urandom_range(1) == 0) rtc_clk = r[NC*DW-1:0];
        rtc_tmr = r[63 -: NT*DW];
        r = {$urandom(), $urandom()};
        if ($urandom_range(2) == 0) usr_clk = r[NC*DW-1:0];
        if ($urandom_range(2) == 0) usr_tmr = r[63 -: NT*DW];
    endtask

    initial begin
        reset   = 1'b1;
        en_cfg  = 1'b0;
        sel_tmr = 1'b0;
        cursor  = '0;
        usr_clk = '0;
        usr_tmr = '0;
        rtc_clk = '0;
        rtc_tmr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Live RTC data in RUN
        rtc_clk[7:0] = 8'h42;
        step();
        check("t1_seg", 64'(vga_clk[7:0]), 64'h42);

        // Clock edit and commit
        en_cfg = 1'b1;
        sel_tmr = 1'b0;
        usr_clk[15:8] = 8'h15;
        repeat (3) step();
        check("t2_min", 64'(vga_clk[15:8]), 64'h15);
        check("t2_cfg", 64'({configurate, crono}), 64'b10);
        en_cfg = 1'b0;
        step();
        check("t2_commit", 64'(commit_clk), 64'd1);
        step();
        check("t2_commit_end", 64'(commit_clk), 64'd0);

        // Timer edit shows the frozen clock snapshot
        en_cfg = 1'b1;
        sel_tmr = 1'b1;
        rtc_clk[7:0] = 8'h10;
        repeat (2) step();
        rtc_clk[7:0] = 8'h11;
        usr_tmr = 24'h123456;
        step();
        check("t3_snap", 64'(vga_clk[7:0]), 64'h10);
        step();
        check("t3_snap_hold", 64'(vga_clk[7:0]), 64'h10);
        check("t3_usr_tmr", 64'(vga_tmr), 64'h123456);

        // Blink on cursor 2, then out-of-range cursor
        sel_tmr = 1'b0;
        cursor = 3'd2;
        repeat (20) step();
        cursor = 3'd7;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_no_wrap", 64'(blank_clk), 64'd0);
        end

        // Exit and group switch in the same cycle
        en_cfg = 1'b0;
        sel_tmr = 1'b1;
        step();
        check("t5_commit", 64'({commit_clk, commit_tmr}), 64'b10);

        // Reset during timer edit
        en_cfg = 1'b1;
        repeat (6) step();
        reset_mid();
        rtc_clk[7:0] = 8'h37;
        step();
        check("t6_live", 64'(vga_clk[7:0]), 64'h37);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if ($urandom_range(399) == 0) reset_mid();
            else step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
